// File: rtl/rot_pkg.sv
// Shared types and helpers for the encoder lane rotate controller.
package rot_pkg;

  localparam int DEF_NUM_LANES = 25;
  localparam int DEF_LANE_W    = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DO    = 3'd2,
    ST_WRITE = 3'd3,
    ST_RUN   = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Full 32-bit product before the modulo so large lane indices cannot wrap early.
  function automatic logic [31:0] rot_ofs_f(input logic [31:0] lane,
                                            input logic [31:0] base,
                                            input logic [31:0] step,
                                            input logic [31:0] lane_w);
    return (base + lane * step) % lane_w;
  endfunction

endpackage

// File: rtl/lane_counter.sv
// Mod-NUM_LANES lane index counter with clear, enable and last-lane flag.
module lane_counter
  import rot_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] next_count,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LANES - 1);

  logic [ADDR_W-1:0] count_r;

  // Next count: clear wins, wrap to zero after the final lane.
  always_comb begin
    last       = (count_r == LAST_IDX);
    next_count = count_r;
    if (clr) begin
      next_count = {ADDR_W{1'b0}};
    end else if (en) begin
      next_count = last ? {ADDR_W{1'b0}} : count_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      next_count = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_r <= {ADDR_W{1'b0}};
    else     count_r <= next_count;
  end

endmodule

// File: rtl/lane_rotate_ctrl.sv
// Lane sequencer for the encoder rotate step (read -> rotate -> write-back per lane).
// Define LANE_ROTATE_PIPE_EN for the pipelined one-lane-per-cycle variant.
module lane_rotate_ctrl
  import rot_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int ADDR_W    = 5,
  parameter int LANE_W    = DEF_LANE_W,
  parameter int OFS_W     = 6,
  parameter int ROT_BASE  = 1,
  parameter int ROT_STEP  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              do_en,
  output logic [OFS_W-1:0]  rot_ofs,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  state_t            state_r, state_nxt_s;
  logic              lane_clr_s, lane_en_s, lane_last_s;
  logic [ADDR_W-1:0] lane_nxt_s;
  logic [ADDR_W-1:0] ofs_lane_s;
  logic [OFS_W-1:0]  rot_ofs_s;

  lane_counter #(.NUM_LANES(NUM_LANES), .ADDR_W(ADDR_W)) u_lane (
    .clk        (clk),
    .rst        (rst),
    .clr        (lane_clr_s),
    .en         (lane_en_s),
    .next_count (lane_nxt_s),
    .last       (lane_last_s)
  );

`ifdef LANE_ROTATE_PIPE_EN
  logic              drain_r, drain_nxt_s;
  logic [ADDR_W-1:0] do_lane_r;
  logic              stage_go_s;

  assign ofs_lane_s = rd_addr;
  assign stage_go_s = rd_en && !abort;

  // Pipelined sequencing: RUN issues one read per cycle, DRAIN empties two stages.
  always_comb begin
    state_nxt_s = state_r;
    lane_clr_s  = 1'b0;
    lane_en_s   = 1'b0;
    drain_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        lane_clr_s = 1'b1;
        if (start && !abort) state_nxt_s = ST_RUN;
        else                 state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
          lane_clr_s  = 1'b1;
        end else begin
          lane_en_s   = 1'b1;
          state_nxt_s = lane_last_s ? ST_DRAIN : ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
          lane_clr_s  = 1'b1;
        end else if (drain_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
          drain_nxt_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        lane_clr_s  = 1'b1;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        lane_clr_s  = 1'b1;
      end
    endcase
  end

  // Drain cycle tracker and the lane index carried into the write stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_r   <= 1'b0;
      do_lane_r <= {ADDR_W{1'b0}};
    end else begin
      drain_r   <= drain_nxt_s;
      do_lane_r <= stage_go_s ? rd_addr : {ADDR_W{1'b0}};
    end
  end
`else
  assign ofs_lane_s = lane_nxt_s;

  // Sequential sequencing: three cycles per lane, at most one strobe active.
  always_comb begin
    state_nxt_s = state_r;
    lane_clr_s  = 1'b0;
    lane_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        lane_clr_s = 1'b1;
        if (start && !abort) state_nxt_s = ST_READ;
        else                 state_nxt_s = ST_IDLE;
      end
      ST_READ: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
          lane_clr_s  = 1'b1;
        end else begin
          state_nxt_s = ST_DO;
        end
      end
      ST_DO: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
          lane_clr_s  = 1'b1;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
          lane_clr_s  = 1'b1;
        end else begin
          lane_en_s   = 1'b1;
          state_nxt_s = lane_last_s ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        lane_clr_s  = 1'b1;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        lane_clr_s  = 1'b1;
      end
    endcase
  end
`endif

  assign rot_ofs_s = OFS_W'(rot_ofs_f(32'(ofs_lane_s), 32'(ROT_BASE), 32'(ROT_STEP), 32'(LANE_W)));

  // State and outputs registered from the next-state decode, so they line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= {ADDR_W{1'b0}};
      do_en   <= 1'b0;
      rot_ofs <= {OFS_W{1'b0}};
      wr_en   <= 1'b0;
      wr_addr <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ready   <= (state_nxt_s == ST_IDLE);
      done    <= (state_nxt_s == ST_DONE);
      busy    <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
`ifdef LANE_ROTATE_PIPE_EN
      rd_en   <= (state_nxt_s == ST_RUN);
      rd_addr <= (state_nxt_s == ST_RUN) ? lane_nxt_s : {ADDR_W{1'b0}};
      do_en   <= stage_go_s;
      rot_ofs <= stage_go_s ? rot_ofs_s : {OFS_W{1'b0}};
      wr_en   <= do_en && !abort;
      wr_addr <= (do_en && !abort) ? do_lane_r : {ADDR_W{1'b0}};
`else
      rd_en   <= (state_nxt_s == ST_READ);
      rd_addr <= (state_nxt_s == ST_READ) ? lane_nxt_s : {ADDR_W{1'b0}};
      do_en   <= (state_nxt_s == ST_DO);
      rot_ofs <= (state_nxt_s == ST_DO) ? rot_ofs_s : {OFS_W{1'b0}};
      wr_en   <= (state_nxt_s == ST_WRITE);
      wr_addr <= (state_nxt_s == ST_WRITE) ? lane_nxt_s : {ADDR_W{1'b0}};
`endif
    end
  end

endmodule

// File: tb/tb_lane_rotate_ctrl.sv
// Scoreboard bench for lane_rotate_ctrl: NUM_LANES=4 at LANE_W=64 (dut a) and LANE_W=16 (dut b).
module tb_lane_rotate_ctrl;

  localparam int N = 4;

  typedef struct {
    logic       ready;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [4:0] rd_addr;
    logic       do_en;
    logic [5:0] ofs64;
    logic [3:0] ofs16;
    logic       wr_en;
    logic [4:0] wr_addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, abort;

  logic       a_ready, a_busy, a_done, a_rd_en, a_do_en, a_wr_en;
  logic [4:0] a_rd_addr, a_wr_addr;
  logic [5:0] a_rot_ofs;
  logic       b_ready, b_busy, b_done, b_rd_en, b_do_en, b_wr_en;
  logic [4:0] b_rd_addr, b_wr_addr;
  logic [3:0] b_rot_ofs;

  exp_t sb[$];
  logic cur_ready;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lane_rotate_ctrl #(.NUM_LANES(N), .ADDR_W(5), .LANE_W(64), .OFS_W(6),
                     .ROT_BASE(1), .ROT_STEP(7)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ready(a_ready), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .do_en(a_do_en), .rot_ofs(a_rot_ofs),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr)
  );

  lane_rotate_ctrl #(.NUM_LANES(N), .ADDR_W(5), .LANE_W(16), .OFS_W(4),
                     .ROT_BASE(1), .ROT_STEP(7)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ready(b_ready), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .do_en(b_do_en), .rot_ofs(b_rot_ofs),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t blank_e();
    exp_t e;
    e.ready = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    e.rd_en = 1'b0; e.rd_addr = 5'd0;
    e.do_en = 1'b0; e.ofs64 = 6'd0; e.ofs16 = 4'd0;
    e.wr_en = 1'b0; e.wr_addr = 5'd0;
    return e;
  endfunction

  // Expected per-cycle outputs of one complete run, pushed when start is accepted.
  task automatic push_run();
    exp_t e;
`ifdef LANE_ROTATE_PIPE_EN
    for (int c = 0; c < N + 2; c++) begin
      e = blank_e();
      e.busy = 1'b1;
      if (c < N) begin e.rd_en = 1'b1; e.rd_addr = 5'(c); end
      if (c >= 1 && c <= N) begin
        e.do_en = 1'b1;
        e.ofs64 = 6'((1 + 7 * (c - 1)) % 64);
        e.ofs16 = 4'((1 + 7 * (c - 1)) % 16);
      end
      if (c >= 2 && c <= N + 1) begin e.wr_en = 1'b1; e.wr_addr = 5'(c - 2); end
      sb.push_back(e);
    end
`else
    for (int l = 0; l < N; l++) begin
      e = blank_e(); e.busy = 1'b1; e.rd_en = 1'b1; e.rd_addr = 5'(l);
      sb.push_back(e);
      e = blank_e(); e.busy = 1'b1; e.do_en = 1'b1;
      e.ofs64 = 6'((1 + 7 * l) % 64); e.ofs16 = 4'((1 + 7 * l) % 16);
      sb.push_back(e);
      e = blank_e(); e.busy = 1'b1; e.wr_en = 1'b1; e.wr_addr = 5'(l);
      sb.push_back(e);
    end
`endif
    e = blank_e(); e.done = 1'b1;
    sb.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    chk("ready",   32'(a_ready),   32'(e.ready));
    chk("busy",    32'(a_busy),    32'(e.busy));
    chk("done",    32'(a_done),    32'(e.done));
    chk("rd_en",   32'(a_rd_en),   32'(e.rd_en));
    chk("rd_addr", 32'(a_rd_addr), 32'(e.rd_addr));
    chk("do_en",   32'(a_do_en),   32'(e.do_en));
    chk("rot_ofs", 32'(a_rot_ofs), 32'(e.ofs64));
    chk("wr_en",   32'(a_wr_en),   32'(e.wr_en));
    chk("wr_addr", 32'(a_wr_addr), 32'(e.wr_addr));
    chk("b_done",  32'(b_done),    32'(e.done));
    chk("b_do_en", 32'(b_do_en),   32'(e.do_en));
    chk("b_rot_ofs16", 32'(b_rot_ofs), 32'(e.ofs16));
  endtask

  // One clock cycle: drive inputs, update the model, compare just after the edge.
  task automatic step(input logic s, input logic a);
    exp_t e;
    start = s;
    abort = a;
    if (a) sb.delete();
    else if (s && cur_ready) push_run();
    @(posedge clk);
    #1;
    if (sb.size() > 0) e = sb.pop_front();
    else begin e = blank_e(); e.ready = 1'b1; end
    cur_ready = e.ready;
    compare(e);
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    exp_t idle;
    idle = blank_e();
    idle.ready = 1'b1;
    cur_ready = 1'b1;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare(idle);
    @(negedge clk);
    rst = 1'b0;

    // Idle, then a plain run.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0);

    // Start pulses throughout a run are ignored until ready returns.
    step(1'b1, 1'b0);
    for (int i = 0; i < 14; i++) step((i % 3) == 0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0);

    // Abort in WRITE of lane 2, then a fresh run from lane 0.
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0);

    // Abort together with start in IDLE must not launch a run.
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    // Asynchronous reset mid-run.
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    cur_ready = 1'b1;
    compare(idle);
    chk("b_ready_rst", 32'(b_ready), 32'(1'b1));
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
